// File: rtl/vhf_pkg.sv
// Shared types and constants for the VHF tuner I2C write master.
package vhf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BYTE,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } state_e;

  localparam logic [6:0]  R820_ADDR  = 7'h1A;
  localparam int unsigned NUM_BYTES  = 3;
  localparam int unsigned BYTE_IDX_W = 2;

  // Byte order on the wire: device write address, register index, register value.
  function automatic logic [7:0] sel_byte(input logic [BYTE_IDX_W-1:0] idx,
                                          input logic [6:0] dev,
                                          input logic [7:0] addr,
                                          input logic [7:0] data);
    case (idx)
      2'd0:    return {dev, 1'b0};
      2'd1:    return addr;
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period tick generator; restart_i re-phases the count to zero.
module i2c_tick_gen #(
  parameter int unsigned CLK_DIV = 48
) (
  input  logic clock,
  input  logic reset,
  input  logic restart_i,
  output logic tick_c_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart_i || (cnt_q == CNT_MAX)) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_c_o = (cnt_q == CNT_MAX) && !restart_i;

endmodule

// File: rtl/vhf_i2c_master.sv
// Single-register I2C write master for the VHF tuner (START, 3 bytes, STOP).
// Define VHF_I2C_ACK_CHECK_EN to abort on NACK and report it on ack_err.
module vhf_i2c_master
  import vhf_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 48,
  parameter logic [6:0]  DEV_ADDR = R820_ADDR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  input  logic       sda_in,
  output logic       vhf_sda,
  output logic       vhf_scl,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(NUM_BYTES - 1);
  localparam logic [7:0]            ADDR_BYTE = {DEV_ADDR, 1'b0};

  state_e                 state_q;
  logic [1:0]             qtr_q;
  logic [2:0]             bit_q;
  logic [BYTE_IDX_W-1:0]  byte_q;
  logic [6:0]             shift_q;
  logic [7:0]             addr_q, data_q;
  logic                   sda_q, scl_q, busy_q, done_q;
  logic                   accept_c, tick_c, stop_early_c;
  logic [7:0]             next_byte_c;

  assign accept_c    = (state_q == ST_IDLE) && start;
  assign next_byte_c = sel_byte(byte_q + BYTE_IDX_W'(1), DEV_ADDR, addr_q, data_q);

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock     (clock),
    .reset     (reset),
    .restart_i (accept_c),
    .tick_c_o  (tick_c)
  );

`ifdef VHF_I2C_ACK_CHECK_EN
  logic ack_err_q;

  // Slave ACK is sampled at the end of the SCL-high window of the ACK slot.
  always_ff @(posedge clock) begin
    if (!reset)                                                  ack_err_q <= 1'b0;
    else if (accept_c)                                           ack_err_q <= 1'b0;
    else if ((state_q == ST_ACK) && tick_c && (qtr_q == 2'd2) && sda_in) ack_err_q <= 1'b1;
  end

  assign stop_early_c = ack_err_q;
  assign ack_err      = ack_err_q;
`else
  logic unused_sda_in;
  assign unused_sda_in = sda_in;
  assign stop_early_c  = 1'b0;
  assign ack_err       = 1'b0;
`endif

  // Sequencer: each branch sets the line levels for the quarter being entered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      qtr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sda_q   <= 1'b1;
      scl_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sda_q <= 1'b1;
          scl_q <= 1'b1;
          if (accept_c) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
            addr_q  <= reg_addr;
            data_q  <= reg_data;
            qtr_q   <= '0;
            byte_q  <= '0;
          end
        end
        ST_START: if (tick_c) begin
          if (qtr_q == 2'd0) begin
            qtr_q <= 2'd1;
            sda_q <= 1'b0;
          end else begin
            state_q <= ST_BYTE;
            qtr_q   <= '0;
            bit_q   <= 3'd7;
            shift_q <= ADDR_BYTE[6:0];
            sda_q   <= ADDR_BYTE[7];
            scl_q   <= 1'b0;
          end
        end
        ST_BYTE: if (tick_c) begin
          qtr_q <= qtr_q + 2'd1;
          case (qtr_q)
            2'd0: scl_q <= 1'b1;
            2'd2: scl_q <= 1'b0;
            2'd3: begin
              if (bit_q == 3'd0) begin
                state_q <= ST_ACK;
                sda_q   <= 1'b1;
              end else begin
                bit_q   <= bit_q - 3'd1;
                sda_q   <= shift_q[6];
                shift_q <= {shift_q[5:0], 1'b0};
              end
            end
            default: ;
          endcase
        end
        ST_ACK: if (tick_c) begin
          qtr_q <= qtr_q + 2'd1;
          case (qtr_q)
            2'd0: scl_q <= 1'b1;
            2'd2: scl_q <= 1'b0;
            2'd3: begin
              if (stop_early_c || (byte_q == LAST_BYTE)) begin
                state_q <= ST_STOP;
                sda_q   <= 1'b0;
                scl_q   <= 1'b1;
              end else begin
                state_q <= ST_BYTE;
                byte_q  <= byte_q + BYTE_IDX_W'(1);
                bit_q   <= 3'd7;
                shift_q <= next_byte_c[6:0];
                sda_q   <= next_byte_c[7];
              end
            end
            default: ;
          endcase
        end
        ST_STOP: if (tick_c) begin
          if (qtr_q == 2'd0) begin
            qtr_q <= 2'd1;
            sda_q <= 1'b1;
          end else begin
            state_q <= ST_DONE;
            qtr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign vhf_sda = sda_q;
  assign vhf_scl = scl_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_vhf_i2c_master.sv
// Directed bench for vhf_i2c_master with an open-drain bus and a model slave at 0x1A.
module tb_vhf_i2c_master;

  localparam int unsigned CLK_DIV  = 48;
  localparam int          FULL_LAT = 112 * CLK_DIV;
`ifdef VHF_I2C_ACK_CHECK_EN
  localparam int   NACK_BYTES = 1;
  localparam int   NACK_RISES = 10;
  localparam int   NACK_LAT   = 40 * CLK_DIV;
  localparam logic NACK_ERR   = 1'b1;
`else
  localparam int   NACK_BYTES = 3;
  localparam int   NACK_RISES = 28;
  localparam int   NACK_LAT   = 112 * CLK_DIV;
  localparam logic NACK_ERR   = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] reg_data = 8'h00;
  logic       vhf_sda, vhf_scl, busy, done, ack_err;
  logic       slave_sda = 1'b1;
  logic       sda_line;

  assign sda_line = vhf_sda & slave_sda;

  vhf_i2c_master #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h1A)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .sda_in   (sda_line),
    .vhf_sda  (vhf_sda),
    .vhf_scl  (vhf_scl),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;

  // Monitor and slave state
  int         cyc = 0;
  int         rise_cyc = 0, last_lat = 0;
  int         done_cnt = 0, done_long = 0, done_busy = 0;
  int         n_start = 0, n_stop = 0, n_rise = 0;
  logic       busy_p = 1'b0, done_p = 1'b0, scl_p = 1'b1, sda_p = 1'b1;
  logic       nack_all = 1'b0;
  logic       in_frame = 1'b0, in_ack = 1'b0, addr_ok = 1'b0;
  int         bitcnt = 0, frame_bytes = 0;
  logic [7:0] cur = 8'h00;
  logic [7:0] got[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (busy && !busy_p) rise_cyc = cyc;
    if (done) begin
      done_cnt++;
      last_lat = cyc - rise_cyc;
      if (done_p) done_long++;
      if (busy)   done_busy++;
    end
    busy_p = busy;
    done_p = done;
    if (!reset) begin
      slave_sda = 1'b1; in_frame = 1'b0; in_ack = 1'b0; bitcnt = 0;
    end else if (scl_p && vhf_scl && sda_p && !sda_line) begin
      n_start++; in_frame = 1'b1; in_ack = 1'b0; bitcnt = 0;
      frame_bytes = 0; addr_ok = 1'b0; slave_sda = 1'b1;
    end else if (scl_p && vhf_scl && !sda_p && sda_line) begin
      n_stop++; in_frame = 1'b0; in_ack = 1'b0; slave_sda = 1'b1;
    end else if (in_frame && !scl_p && vhf_scl) begin
      n_rise++;
      if (!in_ack && bitcnt < 8) begin
        cur = {cur[6:0], sda_line};
        bitcnt++;
        if (bitcnt == 8) begin
          got.push_back(cur);
          if (frame_bytes == 0) addr_ok = (cur == 8'h34);
          frame_bytes++;
        end
      end
    end else if (in_frame && scl_p && !vhf_scl) begin
      if (in_ack) begin
        in_ack = 1'b0; slave_sda = 1'b1; bitcnt = 0;
      end else if (bitcnt == 8) begin
        in_ack = 1'b1; slave_sda = nack_all || !addr_ok;
      end
    end
    scl_p = vhf_scl;
    sda_p = sda_line;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] d);
    reg_addr = a; reg_data = d; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      if (done_cnt != base) begin timed_out = 1'b0; break; end
      step(1);
    end
    step(2);
  endtask

  function automatic logic [7:0] byte_at(input int i);
    if (i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  task automatic test_reset();
    reset = 1'b0; start = 1'b1;
    step(3);
    n_cmp++; if (vhf_sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1", vhf_sda); end
    n_cmp++; if (vhf_scl !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b want 1", vhf_scl); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
    start = 1'b0; reset = 1'b1;
    step(3);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    int base, s0, p0, r0; bit to;
    base = done_cnt; s0 = n_start; p0 = n_stop; r0 = n_rise; got.delete(); nack_all = 1'b0;
    launch(8'h05, 8'h83);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_rise: got %b want 1", busy); end
    wait_done(base, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL wr_timeout: got %b want 0", to); end
    n_cmp++; if (got.size() !== 3) begin n_fail++; $display("FAIL wr_nbytes: got %0d want 3", got.size()); end
    n_cmp++; if (byte_at(0) !== 8'h34) begin n_fail++; $display("FAIL wr_byte0: got %h want 34", byte_at(0)); end
    n_cmp++; if (byte_at(1) !== 8'h05) begin n_fail++; $display("FAIL wr_byte1: got %h want 05", byte_at(1)); end
    n_cmp++; if (byte_at(2) !== 8'h83) begin n_fail++; $display("FAIL wr_byte2: got %h want 83", byte_at(2)); end
    n_cmp++; if (last_lat !== FULL_LAT) begin n_fail++; $display("FAIL wr_latency: got %0d want %0d", last_lat, FULL_LAT); end
    n_cmp++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL wr_ack_err: got %b want 0", ack_err); end
    n_cmp++; if (done_cnt - base !== 1) begin n_fail++; $display("FAIL wr_done_count: got %0d want 1", done_cnt - base); end
    n_cmp++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL wr_start_cond: got %0d want 1", n_start - s0); end
    n_cmp++; if (n_stop - p0 !== 1) begin n_fail++; $display("FAIL wr_stop_cond: got %0d want 1", n_stop - p0); end
    n_cmp++; if (n_rise - r0 !== 28) begin n_fail++; $display("FAIL wr_scl_rises: got %0d want 28", n_rise - r0); end
    n_cmp++; if (done_long !== 0) begin n_fail++; $display("FAIL wr_done_width: got %0d want 0", done_long); end
    n_cmp++; if (done_busy !== 0) begin n_fail++; $display("FAIL wr_done_busy_overlap: got %0d want 0", done_busy); end
    n_cmp++; if ({vhf_sda, vhf_scl} !== 2'b11) begin n_fail++; $display("FAIL wr_idle_lines: got %b want 11", {vhf_sda, vhf_scl}); end
  endtask

  task automatic test_nack();
    int base, p0, r0; bit to;
    base = done_cnt; p0 = n_stop; r0 = n_rise; got.delete(); nack_all = 1'b1;
    launch(8'h11, 8'h22);
    wait_done(base, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL nack_timeout: got %b want 0", to); end
    n_cmp++; if (got.size() !== NACK_BYTES) begin n_fail++; $display("FAIL nack_nbytes: got %0d want %0d", got.size(), NACK_BYTES); end
    n_cmp++; if (byte_at(0) !== 8'h34) begin n_fail++; $display("FAIL nack_byte0: got %h want 34", byte_at(0)); end
    n_cmp++; if (n_rise - r0 !== NACK_RISES) begin n_fail++; $display("FAIL nack_scl_rises: got %0d want %0d", n_rise - r0, NACK_RISES); end
    n_cmp++; if (n_stop - p0 !== 1) begin n_fail++; $display("FAIL nack_stop_cond: got %0d want 1", n_stop - p0); end
    n_cmp++; if (last_lat !== NACK_LAT) begin n_fail++; $display("FAIL nack_latency: got %0d want %0d", last_lat, NACK_LAT); end
    n_cmp++; if (ack_err !== NACK_ERR) begin n_fail++; $display("FAIL nack_ack_err: got %b want %b", ack_err, NACK_ERR); end
    step(20);
    n_cmp++; if (ack_err !== NACK_ERR) begin n_fail++; $display("FAIL nack_ack_err_held: got %b want %b", ack_err, NACK_ERR); end
    nack_all = 1'b0; base = done_cnt; got.delete();
    launch(8'h0A, 8'h5C);
    n_cmp++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL nack_clear_on_start: got %b want 0", ack_err); end
    wait_done(base, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL nack_good_timeout: got %b want 0", to); end
    n_cmp++; if (byte_at(2) !== 8'h5C) begin n_fail++; $display("FAIL nack_good_byte2: got %h want 5c", byte_at(2)); end
    n_cmp++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL nack_good_ack_err: got %b want 0", ack_err); end
  endtask

  task automatic test_back_to_back();
    int base, s0; bit to;
    base = done_cnt; s0 = n_start; got.delete(); to = 1'b1;
    reg_addr = 8'h10; reg_data = 8'h20;
    for (int i = 0; i < 8000; i++) begin
      start = 1'b1;
      step(1);
      if (done === 1'b1) begin to = 1'b0; break; end
    end
    start = 1'b0;
    step(50);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: got %b want 0", to); end
    n_cmp++; if (done_cnt - base !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt - base); end
    n_cmp++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL b2b_start_cond: got %0d want 1", n_start - s0); end
    n_cmp++; if (got.size() !== 3) begin n_fail++; $display("FAIL b2b_nbytes: got %0d want 3", got.size()); end
    n_cmp++; if (last_lat !== FULL_LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", last_lat, FULL_LAT); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    int base, s0; bit to;
    launch(8'h33, 8'h44);
    step(999);
    reset = 1'b0;
    step(1);
    n_cmp++; if ({vhf_sda, vhf_scl} !== 2'b11) begin n_fail++; $display("FAIL abort_lines: got %b want 11", {vhf_sda, vhf_scl}); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
    reset = 1'b1;
    step(5);
    base = done_cnt; s0 = n_start; got.delete();
    launch(8'h07, 8'h99);
    wait_done(base, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL abort_fresh_timeout: got %b want 0", to); end
    n_cmp++; if (byte_at(1) !== 8'h07) begin n_fail++; $display("FAIL abort_fresh_byte1: got %h want 07", byte_at(1)); end
    n_cmp++; if (byte_at(2) !== 8'h99) begin n_fail++; $display("FAIL abort_fresh_byte2: got %h want 99", byte_at(2)); end
    n_cmp++; if (last_lat !== FULL_LAT) begin n_fail++; $display("FAIL abort_fresh_latency: got %0d want %0d", last_lat, FULL_LAT); end
    n_cmp++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL abort_fresh_start: got %0d want 1", n_start - s0); end
  endtask

  task automatic test_protocol();
    int base, s0, p0; bit to;
    base = done_cnt; s0 = n_start; p0 = n_stop; got.delete();
    launch(8'h55, 8'hAA);
    wait_done(base, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL proto_timeout: got %b want 0", to); end
    n_cmp++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL proto_sda_fall_scl_high: got %0d want 1", n_start - s0); end
    n_cmp++; if (n_stop - p0 !== 1) begin n_fail++; $display("FAIL proto_sda_rise_scl_high: got %0d want 1", n_stop - p0); end
    n_cmp++; if (byte_at(1) !== 8'h55) begin n_fail++; $display("FAIL proto_byte1: got %h want 55", byte_at(1)); end
    n_cmp++; if (byte_at(2) !== 8'hAA) begin n_fail++; $display("FAIL proto_byte2: got %h want aa", byte_at(2)); end
    n_cmp++; if (done_long !== 0) begin n_fail++; $display("FAIL proto_done_width: got %0d want 0", done_long); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_nack();
    test_back_to_back();
    test_reset_abort();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
